// File: rtl/mac_se_video_out.sv
// Mac SE CRT scan-out: raster counters, frame buffer read addressing and registered
// VIDEO/HSYNC/VSYNC pins, all with one cycle of latency from counter state to pins.
module mac_se_video_out #(
  parameter int unsigned H_ACTIVE   = 512,
  parameter int unsigned H_FP       = 14,
  parameter int unsigned H_SYNC     = 150,
  parameter int unsigned H_BP       = 28,
  parameter int unsigned V_ACTIVE   = 342,
  parameter int unsigned V_FP       = 0,
  parameter int unsigned V_SYNC     = 4,
  parameter int unsigned V_BP       = 24,
  parameter bit          INVERT     = 1'b1,
  parameter int unsigned ADDR_WIDTH = 18
) (
  input  logic                  read_clk,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic                  fb_read_enable,
  output logic [ADDR_WIDTH-1:0] fb_read_addr,
  input  logic                  fb_read_data,
  output logic                  video_out,
  output logic                  hsync_n,
  output logic                  vsync_n,
  output logic                  frame_start,
  output logic [9:0]            h_count,
  output logic [8:0]            v_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024) begin : g_bad_h_total
    $error("H_TOTAL does not fit the 10-bit h_count");
  end
  if (V_TOTAL > 512) begin : g_bad_v_total
    $error("V_TOTAL does not fit the 9-bit v_count");
  end
  // The address counter parks at H_ACTIVE*V_ACTIVE after the last pixel, so that must fit too.
  if (longint'(H_ACTIVE) * longint'(V_ACTIVE) >= (longint'(1) << ADDR_WIDTH)) begin : g_bad_addr
    $error("ADDR_WIDTH too small for H_ACTIVE*V_ACTIVE");
  end

  // One extra bit so a sync end equal to the line/frame total still compares correctly.
  localparam logic [10:0] HActive    = 11'(H_ACTIVE);
  localparam logic [10:0] HSyncStart = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSyncEnd   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  HLast      = 10'(H_TOTAL - 1);
  localparam logic [9:0]  VActive    = 10'(V_ACTIVE);
  localparam logic [9:0]  VSyncStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [8:0]  VLast      = 9'(V_TOTAL - 1);

  logic                  run_q;
  logic [9:0]            h_q, h_d;
  logic [8:0]            v_q, v_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  video_q, video_d;
  logic                  hsync_n_q, hsync_n_d;
  logic                  vsync_n_q, vsync_n_d;
  logic                  frame_start_q, frame_start_d;

  logic advance;
  logic h_wrap, v_wrap;
  logic in_active, in_hsync, in_vsync;

  // run_q delays enable by one edge so the counters sit at (0,0) for one full cycle
  // before the first stage-1 capture; that keeps frame_start aligned with pixel (0,0).
  always_comb begin
    advance   = run_q & enable;
    h_wrap    = (h_q == HLast);
    v_wrap    = (v_q == VLast);
    in_active = ({1'b0, h_q} < HActive) && ({1'b0, v_q} < VActive);
    in_hsync  = ({1'b0, h_q} >= HSyncStart) && ({1'b0, h_q} < HSyncEnd);
    in_vsync  = ({1'b0, v_q} >= VSyncStart) && ({1'b0, v_q} < VSyncEnd);
  end

  // Stage 0: raster counters and running read address.
  always_comb begin
    h_d    = '0;
    v_d    = '0;
    addr_d = '0;
    if (advance) begin
      h_d    = h_wrap ? '0 : h_q + 10'd1;
      v_d    = v_q;
      if (h_wrap) begin
        v_d = v_wrap ? '0 : v_q + 9'd1;
      end
      addr_d = addr_q;
      if (h_wrap && v_wrap) begin
        addr_d = '0;
      end else if (in_active) begin
        addr_d = addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Stage 1: pixel and sync capture; idles to black with syncs released when not running.
  always_comb begin
    video_d       = INVERT;
    hsync_n_d     = 1'b1;
    vsync_n_d     = 1'b1;
    frame_start_d = 1'b0;
    if (advance) begin
      video_d       = in_active ? (fb_read_data ^ INVERT) : INVERT;
      hsync_n_d     = ~in_hsync;
      vsync_n_d     = ~in_vsync;
      frame_start_d = (h_q == '0) && (v_q == '0);
    end
  end

  always_ff @(posedge read_clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q         <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      addr_q        <= '0;
      video_q       <= INVERT;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      run_q         <= enable;
      h_q           <= h_d;
      v_q           <= v_d;
      addr_q        <= addr_d;
      video_q       <= video_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign fb_read_enable = run_q & in_active;
  assign fb_read_addr   = addr_q;
  assign video_out      = video_q;
  assign hsync_n        = hsync_n_q;
  assign vsync_n        = vsync_n_q;
  assign frame_start    = frame_start_q;
  assign h_count        = h_q;
  assign v_count        = v_q;

endmodule

// File: tb/tb_mac_se_video_out.sv
// Bench for mac_se_video_out: a full-size Mac SE instance plus a miniature raster instance,
// both checked every cycle against a position-from-elapsed-time reference model.
module tb_mac_se_video_out;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b1;
  logic data_one = 1'b0;
  logic [31:0] seed;

  always #5 clk = ~clk;

  // Geometry: index 0 = default Mac SE instance, index 1 = miniature instance.
  int g_ha  [2] = '{512, 16};
  int g_hfp [2] = '{14, 2};
  int g_hs  [2] = '{150, 4};
  int g_hbp [2] = '{28, 3};
  int g_va  [2] = '{342, 6};
  int g_vfp [2] = '{0, 0};
  int g_vs  [2] = '{4, 2};
  int g_vbp [2] = '{24, 3};
  bit g_inv [2] = '{1'b1, 1'b0};

  logic        b_fre, b_vid, b_hs, b_vs, b_fs, b_data;
  logic [17:0] b_addr;
  logic [9:0]  b_h;
  logic [8:0]  b_v;
  logic        s_fre, s_vid, s_hs, s_vs, s_fs, s_data;
  logic [6:0]  s_addr;
  logic [9:0]  s_h;
  logic [8:0]  s_v;

  // Frame buffer contents: pseudo-random per run, with the known pixels forced on the big one.
  function automatic bit mem_bit(input int w, input int addr, input logic [31:0] s);
    logic [31:0] hsh;
    if (w == 0 && addr == 0)   return 1'b1;
    if (w == 0 && addr == 511) return 1'b0;
    if (w == 0 && addr == 512) return 1'b1;
    hsh = (32'(addr) ^ s) * 32'h9E3779B1;
    return hsh[29] ^ hsh[13];
  endfunction

  assign b_data = data_one | mem_bit(0, int'(b_addr), seed);
  assign s_data = data_one | mem_bit(1, int'(s_addr), seed);

  mac_se_video_out u_big (
    .read_clk(clk), .reset_n(reset_n), .enable(enable),
    .fb_read_enable(b_fre), .fb_read_addr(b_addr), .fb_read_data(b_data),
    .video_out(b_vid), .hsync_n(b_hs), .vsync_n(b_vs), .frame_start(b_fs),
    .h_count(b_h), .v_count(b_v)
  );

  mac_se_video_out #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(0), .V_SYNC(2), .V_BP(3),
    .INVERT(1'b0), .ADDR_WIDTH(7)
  ) u_sml (
    .read_clk(clk), .reset_n(reset_n), .enable(enable),
    .fb_read_enable(s_fre), .fb_read_addr(s_addr), .fb_read_data(s_data),
    .video_out(s_vid), .hsync_n(s_hs), .vsync_n(s_vs), .frame_start(s_fs),
    .h_count(s_h), .v_count(s_v)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_steps  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at step %0d: got %0h, want %0h", tag, n_steps, got, exp);
    end
  endtask

  // Reference model: m_t = pixels elapsed since the raster last sat at (0,0);
  // m_run = stage 0 is live; m_* = what the pins should show right now.
  int m_t   [2];
  bit m_run [2];
  bit m_vid [2];
  bit m_hs  [2];
  bit m_vs  [2];
  bit m_fs  [2];

  function automatic int ht(input int w);
    return g_ha[w] + g_hfp[w] + g_hs[w] + g_hbp[w];
  endfunction
  function automatic int vt(input int w);
    return g_va[w] + g_vfp[w] + g_vs[w] + g_vbp[w];
  endfunction
  function automatic int mx(input int w);
    return m_t[w] % ht(w);
  endfunction
  function automatic int my(input int w);
    return m_t[w] / ht(w);
  endfunction
  function automatic bit in_act(input int w);
    return (mx(w) < g_ha[w]) && (my(w) < g_va[w]);
  endfunction
  function automatic int exp_addr(input int w);
    if (my(w) >= g_va[w]) return g_ha[w] * g_va[w];
    return my(w) * g_ha[w] + ((mx(w) < g_ha[w]) ? mx(w) : g_ha[w]);
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_t[w] = 0; m_run[w] = 1'b0; m_vid[w] = g_inv[w];
      m_hs[w] = 1'b1; m_vs[w] = 1'b1; m_fs[w] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int w = 0; w < 2; w++) begin
      int x, y, hs0, vs0;
      bit live, d;
      x = mx(w); y = my(w);
      hs0 = g_ha[w] + g_hfp[w];
      vs0 = g_va[w] + g_vfp[w];
      live = m_run[w] && enable;
      d = data_one | mem_bit(w, exp_addr(w), seed);
      if (live) begin
        m_vid[w] = in_act(w) ? (d ^ g_inv[w]) : g_inv[w];
        m_hs[w]  = !(x >= hs0 && x < hs0 + g_hs[w]);
        m_vs[w]  = !(y >= vs0 && y < vs0 + g_vs[w]);
        m_fs[w]  = (m_t[w] == 0);
        m_t[w]   = (m_t[w] + 1) % (ht(w) * vt(w));
      end else begin
        m_vid[w] = g_inv[w]; m_hs[w] = 1'b1; m_vs[w] = 1'b1; m_fs[w] = 1'b0;
        m_t[w]   = 0;
      end
      m_run[w] = enable;
    end
  endtask

  task automatic check_outputs();
    check_eq("big.rd_en", b_fre, m_run[0] && in_act(0));
    check_eq("big.addr", b_addr, exp_addr(0));
    check_eq("big.h", b_h, mx(0));
    check_eq("big.v", b_v, my(0));
    check_eq("big.video", b_vid, m_vid[0]);
    check_eq("big.hsync_n", b_hs, m_hs[0]);
    check_eq("big.vsync_n", b_vs, m_vs[0]);
    check_eq("big.frame_start", b_fs, m_fs[0]);
    check_eq("sml.rd_en", s_fre, m_run[1] && in_act(1));
    check_eq("sml.addr", s_addr, exp_addr(1));
    check_eq("sml.h", s_h, mx(1));
    check_eq("sml.v", s_v, my(1));
    check_eq("sml.video", s_vid, m_vid[1]);
    check_eq("sml.hsync_n", s_hs, m_hs[1]);
    check_eq("sml.vsync_n", s_vs, m_vs[1]);
    check_eq("sml.frame_start", s_fs, m_fs[1]);
  endtask

  // Directed timing trackers, with cycle 0 = first cycle the raster sits at (0,0) live.
  bit track_on = 1'b0;
  int cyc, bh_first, bh_last, bh_run, sf_last, sv_run;
  bit prev_bhs, prev_svs;

  task automatic start_track();
    track_on = 1'b1; cyc = -1; bh_first = -1; bh_last = -1; bh_run = 0;
    sf_last = -1; sv_run = 0; prev_bhs = 1'b1; prev_svs = 1'b1;
  endtask

  task automatic stop_track();
    check_eq("big.hs_first", bh_first, 527);
    track_on = 1'b0;
  endtask

  task automatic track();
    if (!b_hs) begin
      bh_run++;
      if (prev_bhs) begin
        if (bh_first < 0) bh_first = cyc;
        else check_eq("big.hs_period", cyc - bh_last, 704);
        bh_last = cyc;
      end
    end else if (!prev_bhs) begin
      check_eq("big.hs_width", bh_run, 150);
      bh_run = 0;
    end
    if (b_fs) check_eq("big.fs_cycle", cyc, 1);
    if (s_fs) begin
      if (sf_last < 0) check_eq("sml.fs_first", cyc, 1);
      else check_eq("sml.fs_period", cyc - sf_last, 275);
      sf_last = cyc;
    end
    if (!s_vs) sv_run++;
    else if (!prev_svs) begin
      check_eq("sml.vs_width", sv_run, 50);
      sv_run = 0;
    end
    prev_bhs = b_hs;
    prev_svs = s_vs;
  endtask

  // Called at a falling edge: check the pins, then advance the model across the next rising edge.
  task automatic step();
    check_outputs();
    if (track_on) track();
    if (!reset_n) model_reset();
    else model_edge();
    cyc++;
    n_steps++;
    @(negedge clk);
  endtask

  initial begin
    bit found;
    seed = $urandom;
    model_reset();
    @(negedge clk);
    repeat (3) step();

    // Release with enable high; run the big raster for three lines, the small one for 8 frames.
    reset_n = 1'b1;
    start_track();
    repeat (2200) step();
    stop_track();

    // Blanking must ignore a stuck-high data bus.
    data_one = 1'b1;
    repeat (300) step();
    data_one = 1'b0;

    // Drop enable mid-line at pixel 200, then resume.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (mx(0) == 200) found = 1'b1;
      else step();
    end
    enable = 1'b0;
    repeat (4) step();
    enable = 1'b1;
    repeat (1200) step();

    // Random enable glitches.
    repeat (1500) begin
      enable = ($urandom_range(39, 0) != 0);
      step();
    end
    enable = 1'b1;
    repeat (300) step();

    // Asynchronous reset between edges: pins must clear without a clock.
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    repeat (3) step();
    reset_n = 1'b1;
    start_track();
    repeat (1500) step();
    stop_track();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
